// File: rtl/sift_img_pkg.sv
// Shared image geometry and loader state encoding for the SIFT front end.
// Contents: IMG_W, IMG_H, PIX_W, ADDR_W, ROW_W, COL_W, loader_state_t.
package sift_img_pkg;

    localparam int unsigned IMG_W  = 640;
    localparam int unsigned IMG_H  = 480;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned ROW_W  = IMG_W * PIX_W;
    localparam int unsigned COL_W  = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        FILL     = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4
    } loader_state_t;

endpackage

// File: rtl/image_row_loader_if.sv
// Raster pixel stream with valid/ready handshake and start-of-frame marker.
// master: pixel source (drives valid/data/sof), slave: loader (drives ready).
interface image_row_loader_if #(
    parameter int unsigned PIX_W = sift_img_pkg::PIX_W
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;

    modport master (output pix_valid, output pix_data, output pix_sof, input pix_ready);
    modport slave  (input pix_valid, input pix_data, input pix_sof, output pix_ready);
endinterface

// File: rtl/pixel_row_packer.sv
// Row packer: NPIX x PIX_W shift register. New pixels enter at the MSB end and
// move toward the LSB, so after NPIX shifts the first pixel sits at [PIX_W-1:0].
// Ports: clk, clear (synchronous), shift_en, pix (input pixel), row_word (packed row).
module pixel_row_packer #(
    parameter int unsigned NPIX  = sift_img_pkg::IMG_W,
    parameter int unsigned PIX_W = sift_img_pkg::PIX_W
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [PIX_W-1:0]      pix,
    output logic [NPIX*PIX_W-1:0] row_word
);

    localparam int unsigned ROW_W = NPIX * PIX_W;

    always_ff @(posedge clk) begin
        if (clear) begin
            row_word <= '0;
        end else if (shift_en) begin
            row_word <= {pix, row_word[ROW_W-1:PIX_W]};
        end
    end

endmodule

// File: rtl/image_row_loader.sv
// Image row loader: packs a raster pixel stream into IMG_W-pixel row words and
// writes them to SRAM rows 0..IMG_H-1, then raises load_done as the core start.
// Ports: clk, rst (sync, active-high), load_start, pix (stream slave),
//        mem_we/mem_addr/mem_din (SRAM row write), busy, load_done, sync_err.
// Optional: IMAGE_ROW_LOADER_CHECKSUM_EN adds frame_sum, the mod-2^16 sum of
//           the pixels of the current frame.
module image_row_loader #(
    parameter int unsigned IMG_W  = sift_img_pkg::IMG_W,
    parameter int unsigned IMG_H  = sift_img_pkg::IMG_H,
    parameter int unsigned PIX_W  = sift_img_pkg::PIX_W,
    parameter int unsigned ADDR_W = sift_img_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    image_row_loader_if.slave       pix,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [IMG_W*PIX_W-1:0]  mem_din,
    output logic                    busy,
    output logic                    load_done,
    output logic                    sync_err
`ifdef IMAGE_ROW_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]             frame_sum
`endif
);

    import sift_img_pkg::*;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);

    loader_state_t     state;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row;

    logic xfer;
    logic start_ok;
    logic shift_en;
    logic resync;
    logic pack_clear;

    assign xfer       = pix.pix_valid && pix.pix_ready;
    assign start_ok   = load_start && (state == IDLE || state == DONE);
    // Non-sof pixels in WAIT_SOF are accepted but never reach the packer.
    assign shift_en   = xfer && (state == FILL || (state == WAIT_SOF && pix.pix_sof));
    assign resync     = xfer && state == FILL && pix.pix_sof;
    assign pack_clear = rst || start_ok;

    pixel_row_packer #(
        .NPIX  (IMG_W),
        .PIX_W (PIX_W)
    ) u_packer (
        .clk      (clk),
        .clear    (pack_clear),
        .shift_en (shift_en),
        .pix      (pix.pix_data),
        .row_word (mem_din)
    );

    // Loader FSM; outputs are registered and updated on each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            pix.pix_ready <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state         <= WAIT_SOF;
                        pix.pix_ready <= 1'b1;
                        sync_err      <= 1'b0;
                        row           <= '0;
                        col           <= '0;
                    end
                end
                WAIT_SOF: begin
                    if (xfer && pix.pix_sof) begin
                        state <= FILL;
                        col   <= COL_W'(1);
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        if (pix.pix_sof) begin
                            // Frame-sync slip: this pixel restarts the frame at (0,0).
                            sync_err <= 1'b1;
                            row      <= '0;
                            col      <= COL_W'(1);
                        end else if (col == COL_LAST) begin
                            state         <= WRITE;
                            pix.pix_ready <= 1'b0;
                            mem_we        <= 1'b1;
                            mem_addr      <= row;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                WRITE: begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        row           <= row + ADDR_W'(1);
                        state         <= FILL;
                        pix.pix_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state         <= WAIT_SOF;
                        load_done     <= 1'b0;
                        pix.pix_ready <= 1'b1;
                        sync_err      <= 1'b0;
                        row           <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IMAGE_ROW_LOADER_CHECKSUM_EN
    // Running frame checksum; the first pixel of a (re)synced frame restarts it.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            frame_sum <= '0;
        end else if (shift_en) begin
            if (resync || state == WAIT_SOF) begin
                frame_sum <= 16'(pix.pix_data);
            end else begin
                frame_sum <= frame_sum + 16'(pix.pix_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_image_row_loader.sv
// Self-checking bench for image_row_loader on a reduced 16x6 geometry.
module tb_image_row_loader;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 6;
    localparam int unsigned PW = 8;
    localparam int unsigned AW = 9;
    localparam int unsigned RW = W * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] mem_din;
    logic          busy;
    logic          load_done;
    logic          sync_err;
`ifdef IMAGE_ROW_LOADER_CHECKSUM_EN
    logic [15:0]   frame_sum;
`endif

    image_row_loader_if #(.PIX_W(PW)) bus ();

    image_row_loader #(
        .IMG_W  (W),
        .IMG_H  (H),
        .PIX_W  (PW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .pix        (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .load_done  (load_done),
        .sync_err   (sync_err)
`ifdef IMAGE_ROW_LOADER_CHECKSUM_EN
        ,
        .frame_sum  (frame_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sof;
        logic [7:0] d;
    } px_t;

    typedef struct {
        int            addr;
        logic [RW-1:0] din;
        bit            last;
    } wr_t;

    px_t           stim[$];
    wr_t           exp_q[$];
    wr_t           cur;
    int            wr_log[$];
    logic [RW-1:0] seen[H];
    logic [RW-1:0] ref_mem[H];
    int            n_pass = 0;
    int            n_checks = 0;
    bit            expect_done_next = 1'b0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: turns an intended pixel stream into the row writes it must produce.
    task automatic model_stream(output bit serr);
        bit         synced = 1'b0;
        bit         fin = 1'b0;
        int         row = 0;
        logic [7:0] pq[$];
        wr_t        w;
        serr = 1'b0;
        foreach (stim[i]) begin
            if (fin) continue;
            if (!synced) begin
                if (stim[i].sof) begin
                    synced = 1'b1;
                    pq = {stim[i].d};
                end
                continue;
            end
            if (stim[i].sof) begin
                serr = 1'b1;
                row  = 0;
                pq   = {stim[i].d};
            end else begin
                pq.push_back(stim[i].d);
            end
            if (pq.size() == W) begin
                w.addr = row;
                w.din  = '0;
                for (int c = 0; c < int'(W); c++) w.din[c*8 +: 8] = pq[c];
                w.last = (row == int'(H) - 1);
                exp_q.push_back(w);
                pq = {};
                row++;
                if (row == int'(H)) fin = 1'b1;
            end
        end
    endtask

    // Pixels at linear frame positions [from, to) with value (r*mul + c) & 0xFF.
    task automatic add_pixels(input int mul, input int from, input int to);
        px_t p;
        for (int i = from; i < to; i++) begin
            p.sof = (i == 0);
            p.d   = 8'(((i / int'(W)) * mul + (i % int'(W))) & 255);
            stim.push_back(p);
        end
    endtask

    task automatic add_px(input logic [7:0] d, input logic sof);
        px_t p;
        p.sof = sof;
        p.d   = d;
        stim.push_back(p);
    endtask

    task automatic send_px(input px_t p, input bit gaps);
        bit ok = 1'b0;
        bit r;
        if (gaps) begin
            while ($urandom_range(0, 99) < 30) begin
                bus.pix_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = p.d;
        bus.pix_sof   = p.sof;
        for (int k = 0; k < 64 && !ok; k++) begin
            r = bus.pix_ready;
            @(posedge clk); #1;
            if (r) ok = 1'b1;
        end
        if (!ok) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drive_stream(input bit gaps, input int start_at);
        foreach (stim[i]) begin
            if (i == start_at) load_start = 1'b1;
            send_px(stim[i], gaps);
            load_start = 1'b0;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (load_done) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("load_done_seen", ok, 1'b1);
    endtask

    task automatic run_frame(input bit gaps, input int start_at, output bit serr);
        model_stream(serr);
        drive_stream(gaps, start_at);
        wait_done();
        chk("pending_writes", exp_q.size(), 0);
        chk("sync_err", sync_err, serr);
    endtask

    // Compare process: every SRAM write against the model, plus handshake rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (expect_done_next) begin
                chk("load_done_after_last_write", load_done, 1'b1);
                expect_done_next = 1'b0;
            end
            if (mem_we) begin
                chk("ready_low_in_write", bus.pix_ready, 1'b0);
                chk("done_low_in_write", load_done, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", mem_addr, cur.addr);
                    chk("wr_din", mem_din, cur.din);
                    if (cur.last) expect_done_next = 1'b1;
                end
                if (int'(mem_addr) < int'(H)) seen[mem_addr] = mem_din;
                wr_log.push_back(int'(mem_addr));
            end
            if (load_done) chk("ready_low_in_done", bus.pix_ready, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit serr;
        int base;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_sof   = 1'b0;
        for (int r = 0; r < int'(H); r++) seen[r] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", bus.pix_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_sync_err", sync_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain frame, no gaps; a load_start mid-frame must be ignored.
        base = wr_log.size();
        pulse_start();
        stim = {};
        add_pixels(1, 0, W * H);
        run_frame(1'b0, 40, serr);
        chk("t1_write_count", wr_log.size() - base, H);
        chk("t1_row5_byte0", seen[5][7:0], 8'h05);
        chk("t1_row5_byte15", seen[5][127:120], 8'h14);
        chk("t1_busy_after", busy, 1'b0);
        for (int r = 0; r < int'(H); r++) ref_mem[r] = seen[r];

        // Same frame with random valid gaps must give identical rows.
        for (int r = 0; r < int'(H); r++) seen[r] = '0;
        pulse_start();
        chk("t2_done_dropped", load_done, 1'b0);
        run_frame(1'b1, -1, serr);
        for (int r = 0; r < int'(H); r++) chk("t2_row_match", seen[r], ref_mem[r]);

        // Non-sof pixels before sof are dropped.
        pulse_start();
        stim = {};
        add_px(8'h11, 1'b0);
        add_px(8'h22, 1'b0);
        add_px(8'h33, 1'b0);
        add_px(8'hA5, 1'b1);
        add_pixels(1, 1, W * H);
        run_frame(1'b0, -1, serr);
        chk("t3_row0_byte0", seen[0][7:0], 8'hA5);
        chk("t3_row0_byte1", seen[0][15:8], 8'h01);
        chk("t3_sync_err_lit", sync_err, 1'b0);

        // sof mid-frame at row 2 col 10: resync to row 0.
        base = wr_log.size();
        pulse_start();
        stim = {};
        add_pixels(1, 0, 2 * W + 10);
        add_px(8'h5A, 1'b1);
        add_pixels(1, 1, W * H);
        run_frame(1'b1, -1, serr);
        chk("t4_sync_err_lit", sync_err, 1'b1);
        chk("t4_write_count", wr_log.size() - base, H + 2);
        if (wr_log.size() > base + 2) chk("t4_resync_addr", wr_log[base + 2], 0);
        chk("t4_row0_byte0", seen[0][7:0], 8'h5A);

        // Reset mid-row, then a clean frame.
        base = wr_log.size();
        pulse_start();
        stim = {};
        add_pixels(1, 0, 3 * W + 5);
        model_stream(serr);
        drive_stream(1'b0, -1);
        chk("t5_busy_mid", busy, 1'b1);
        chk("t5_pre_writes", wr_log.size() - base, 3);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_rst_ready", bus.pix_ready, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_done", load_done, 1'b0);
        base = wr_log.size();
        pulse_start();
        stim = {};
        add_pixels(7, 0, W * H);
        run_frame(1'b1, -1, serr);
        chk("t5_write_count", wr_log.size() - base, H);
        chk("t5_row1_byte2", seen[1][23:16], 8'h09);

`ifdef IMAGE_ROW_LOADER_CHECKSUM_EN
        pulse_start();
        stim = {};
        add_px(8'h01, 1'b1);
        for (int i = 1; i < int'(W * H); i++) add_px(8'h01, 1'b0);
        run_frame(1'b0, -1, serr);
        chk("checksum_all_ones", frame_sum, 16'h0060);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
